// File: rtl/nes_sram_arbiter_pkg.sv
// Shared types and constants for the NES block-RAM arbiter.
package nes_sram_arb_pkg;

    localparam int RAM_AW  = 15;
    localparam int RAM_DW  = 8;
    localparam int NUM_REQ = 3;

    localparam int REQ_LOADER = 0;
    localparam int REQ_CPU    = 1;
    localparam int REQ_PPU    = 2;

    typedef logic [1:0] req_id_t;

    typedef struct packed {
        logic              v;
        logic              we;
        req_id_t           id;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] wdata;
    } s1_cmd_t;

    function automatic req_id_t onehot_to_id(input logic [NUM_REQ-1:0] g);
        req_id_t id;
        id = '0;
        unique case (1'b1)
            g[REQ_CPU]: id = req_id_t'(REQ_CPU);
            g[REQ_PPU]: id = req_id_t'(REQ_PPU);
            default:    id = req_id_t'(REQ_LOADER);
        endcase
        return id;
    endfunction

endpackage

// File: rtl/nes_sram_arbiter_if.sv
// Requester-side bus of the arbiter: valid/ack command handshake
// plus tagged read-return.
interface nes_sram_arbiter_if #(
    parameter int NREQ = nes_sram_arb_pkg::NUM_REQ,
    parameter int AW   = nes_sram_arb_pkg::RAM_AW,
    parameter int DW   = nes_sram_arb_pkg::RAM_DW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    rd_valid;
    logic [DW-1:0]      rd_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ack, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ack, rd_valid, rd_data
    );
endinterface

// File: rtl/nes_sram_arbiter_pick.sv
// Combinational grant selector: loader first, then CPU/PPU by prio_ppu.
module nes_sram_arb_pick
    import nes_sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               prio_ppu,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (valid[REQ_LOADER]) begin
            grant[REQ_LOADER] = 1'b1;
        end else if (valid[REQ_CPU] && valid[REQ_PPU]) begin
            if (prio_ppu) grant[REQ_PPU] = 1'b1;
            else          grant[REQ_CPU] = 1'b1;
        end else if (valid[REQ_CPU]) begin
            grant[REQ_CPU] = 1'b1;
        end else if (valid[REQ_PPU]) begin
            grant[REQ_PPU] = 1'b1;
        end
    end

endmodule

// File: rtl/nes_sram_arbiter.sv
// Three-port arbiter in front of a 32KBx8 single-port block RAM.
// SRAM_ARB_RR_EN: CPU/PPU round-robin; otherwise PPU beats CPU.
module nes_sram_arbiter
    import nes_sram_arb_pkg::*;
#(
    parameter int AW   = RAM_AW,
    parameter int DW   = RAM_DW,
    parameter int NREQ = NUM_REQ
) (
    input  logic                clk,
    input  logic                reset,
    nes_sram_arbiter_if.slave   bus,
    output logic                ram_ce,
    output logic                ram_oce,
    output logic                ram_wre,
    output logic [AW-1:0]       ram_ad,
    output logic [DW-1:0]       ram_din,
    input  logic [DW-1:0]       ram_dout
);

    logic [NREQ-1:0] pick_gnt;
    logic [NREQ-1:0] gnt;
    logic            prio_ppu;
    req_id_t         gid;
    s1_cmd_t         s1;
    s1_cmd_t         s1_nxt;
    logic            s2_v;
    req_id_t         s2_id;

    nes_sram_arb_pick u_pick (
        .valid    (bus.req_valid),
        .prio_ppu (prio_ppu),
        .grant    (pick_gnt)
    );

`ifdef SRAM_ARB_RR_EN
    logic rr_ppu;

    // Only CPU/PPU grants advance the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ppu <= 1'b0;
        end else if (gnt[REQ_CPU]) begin
            rr_ppu <= 1'b1;
        end else if (gnt[REQ_PPU]) begin
            rr_ppu <= 1'b0;
        end
    end

    assign prio_ppu = rr_ppu;
`else
    assign prio_ppu = 1'b1;
`endif

    always_comb begin
        gnt = reset ? '0 : pick_gnt;
        gid = onehot_to_id(gnt);
        s1_nxt       = '0;
        s1_nxt.v     = |gnt;
        s1_nxt.we    = bus.req_we[gid];
        s1_nxt.id    = gid;
        s1_nxt.addr  = bus.req_addr[gid*AW +: AW];
        s1_nxt.wdata = bus.req_wdata[gid*DW +: DW];
    end

    assign bus.req_ack = gnt;

    // Address/data hold their last value when idle; ram_ce gates use.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
        end else if (|gnt) begin
            s1 <= s1_nxt;
        end else begin
            s1.v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_v  <= 1'b0;
            s2_id <= '0;
        end else begin
            s2_v  <= s1.v & ~s1.we;
            s2_id <= s1.id;
        end
    end

    assign ram_ce  = s1.v;
    assign ram_oce = 1'b1;
    assign ram_wre = s1.v & s1.we;
    assign ram_ad  = s1.addr;
    assign ram_din = s1.wdata;

    assign bus.rd_valid = s2_v ? (NREQ'(1) << s2_id) : '0;
    assign bus.rd_data  = ram_dout;

endmodule

// File: tb/tb_nes_sram_arbiter.sv
// Directed-vector bench for nes_sram_arbiter with a behavioural
// one-cycle registered-read RAM model.
module tb_nes_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_ce, ram_oce, ram_wre;
    logic [14:0] ram_ad;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [7:0]  mem [0:32767];

    int n_vec = 0;
    int n_err = 0;

    nes_sram_arbiter_if #(.NREQ(3), .AW(15), .DW(8)) bus ();

    nes_sram_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .ram_ce   (ram_ce),
        .ram_oce  (ram_oce),
        .ram_wre  (ram_wre),
        .ram_ad   (ram_ad),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                mem[ram_ad] = ram_din;
                ram_dout <= ram_din;
            end else begin
                ram_dout <= mem[ram_ad];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [14:0] a, input logic [7:0] d);
        bus.req_valid[i]         = v;
        bus.req_we[i]            = we;
        bus.req_addr[i*15 +: 15] = a;
        bus.req_wdata[i*8 +: 8]  = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 15'h0, 8'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_g;

        mem[15'h1234] = 8'hA5;
        mem[15'h3FFF] = 8'h77;
        mem[15'h4000] = 8'h11;
        mem[15'h0100] = 8'h01;
        mem[15'h0200] = 8'h02;
        mem[15'h0300] = 8'h03;

        // reset state, with all requesters trying to get in
        reset = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 15'h0100, 8'h0);
        tick();
        smp();
        chk("rst_ack",   bus.req_ack,  3'b000);
        chk("rst_rdv",   bus.rd_valid, 3'b000);
        chk("rst_ce",    ram_ce,       1'b0);
        chk("rst_wre",   ram_wre,      1'b0);
        chk("rst_ad",    ram_ad,       15'h0);
        chk("rst_din",   ram_din,      8'h0);
        chk("rst_oce",   ram_oce,      1'b1);
        tick();
        reset = 1'b0;
        idle_all();

        // single CPU read
        set_req(1, 1'b1, 1'b0, 15'h1234, 8'h0);
        smp();
        chk("t1_ack", bus.req_ack, 3'b010);
        tick();
        set_req(1, 1'b0, 1'b0, 15'h0, 8'h0);
        smp();
        chk("t1_ce",  ram_ce,      1'b1);
        chk("t1_ad",  ram_ad,      15'h1234);
        chk("t1_wre", ram_wre,     1'b0);
        chk("t1_ack0", bus.req_ack, 3'b000);
        chk("t1_rdv_early", bus.rd_valid, 3'b000);
        tick();
        smp();
        chk("t1_rdv", bus.rd_valid, 3'b010);
        chk("t1_rdd", bus.rd_data,  8'hA5);
        tick();
        smp();
        chk("t1_rdv_end", bus.rd_valid, 3'b000);

        // CPU and PPU contending from reset
        do_reset();
        set_req(1, 1'b1, 1'b0, 15'h0200, 8'h0);
        set_req(2, 1'b1, 1'b0, 15'h0300, 8'h0);
        for (int c = 0; c < 4; c++) begin
            exp_g = (RR && (c % 2 == 0)) ? 3'b010 : 3'b100;
            smp();
            chk($sformatf("t2_ack%0d", c), bus.req_ack, exp_g);
            tick();
        end
        idle_all();
        tick();
        tick();

        // loader dominance; pointer unaffected by loader grants
        do_reset();
        set_req(1, 1'b1, 1'b0, 15'h0200, 8'h0);
        smp();
        chk("t3_cpu", bus.req_ack, 3'b010);
        tick();
        set_req(0, 1'b1, 1'b0, 15'h0100, 8'h0);
        set_req(2, 1'b1, 1'b0, 15'h0300, 8'h0);
        for (int c = 0; c < 3; c++) begin
            smp();
            chk($sformatf("t3_ldr%0d", c), bus.req_ack, 3'b001);
            tick();
        end
        set_req(0, 1'b0, 1'b0, 15'h0, 8'h0);
        smp();
        chk("t3_after", bus.req_ack, 3'b100);
        tick();
        set_req(2, 1'b0, 1'b0, 15'h0, 8'h0);
        smp();
        chk("t3_cpu2", bus.req_ack, 3'b010);
        tick();
        idle_all();
        tick();
        tick();

        // write then immediate read of same address, then neighbour
        do_reset();
        set_req(1, 1'b1, 1'b1, 15'h4000, 8'h3C);
        smp();
        chk("t4_wack", bus.req_ack, 3'b010);
        tick();
        set_req(1, 1'b0, 1'b0, 15'h0, 8'h0);
        set_req(2, 1'b1, 1'b0, 15'h4000, 8'h0);
        smp();
        chk("t4_rack", bus.req_ack, 3'b100);
        chk("t4_wre",  ram_wre,     1'b1);
        chk("t4_wad",  ram_ad,      15'h4000);
        chk("t4_din",  ram_din,     8'h3C);
        tick();
        set_req(2, 1'b1, 1'b0, 15'h3FFF, 8'h0);
        smp();
        chk("t4_wnorv", bus.rd_valid, 3'b000);
        chk("t4_rwre",  ram_wre,      1'b0);
        tick();
        set_req(2, 1'b0, 1'b0, 15'h0, 8'h0);
        smp();
        chk("t4_rdv",  bus.rd_valid, 3'b100);
        chk("t4_rdd",  bus.rd_data,  8'h3C);
        tick();
        smp();
        chk("t4_rdv2", bus.rd_valid, 3'b100);
        chk("t4_rdd2", bus.rd_data,  8'h77);
        tick();
        smp();
        chk("t4_end",  bus.rd_valid, 3'b000);

        // reset while a read is in flight
        tick();
        set_req(1, 1'b1, 1'b0, 15'h1234, 8'h0);
        smp();
        chk("t5_ack", bus.req_ack, 3'b010);
        tick();
        set_req(1, 1'b0, 1'b0, 15'h0, 8'h0);
        reset = 1'b1;
        smp();
        chk("t5_rack", bus.req_ack, 3'b000);
        tick();
        reset = 1'b0;
        smp();
        chk("t5_norv", bus.rd_valid, 3'b000);
        chk("t5_ce",   ram_ce,       1'b0);
        tick();
        set_req(1, 1'b1, 1'b0, 15'h1234, 8'h0);
        smp();
        chk("t5_ack2", bus.req_ack, 3'b010);
        tick();
        set_req(1, 1'b0, 1'b0, 15'h0, 8'h0);
        tick();
        smp();
        chk("t5_rdv", bus.rd_valid, 3'b010);
        chk("t5_rdd", bus.rd_data,  8'hA5);
        tick();

        // back-to-back reads, one per requester
        set_req(0, 1'b1, 1'b0, 15'h0100, 8'h0);
        smp();
        chk("t6_ack0", bus.req_ack, 3'b001);
        tick();
        set_req(0, 1'b0, 1'b0, 15'h0, 8'h0);
        set_req(1, 1'b1, 1'b0, 15'h0200, 8'h0);
        smp();
        chk("t6_ack1", bus.req_ack, 3'b010);
        tick();
        set_req(1, 1'b0, 1'b0, 15'h0, 8'h0);
        set_req(2, 1'b1, 1'b0, 15'h0300, 8'h0);
        smp();
        chk("t6_ack2", bus.req_ack,  3'b100);
        chk("t6_rv0",  bus.rd_valid, 3'b001);
        chk("t6_rd0",  bus.rd_data,  8'h01);
        tick();
        idle_all();
        smp();
        chk("t6_rv1", bus.rd_valid, 3'b010);
        chk("t6_rd1", bus.rd_data,  8'h02);
        tick();
        smp();
        chk("t6_rv2", bus.rd_valid, 3'b100);
        chk("t6_rd2", bus.rd_data,  8'h03);
        tick();
        smp();
        chk("t6_end", bus.rd_valid, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
